// File: rtl/led_pkg.sv
// Shared definitions for the LED bank: channel drive modes.
// Latency: n/a. Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Time-base divider: one-clk tick every PRESC_DIV clocks, decoded from the registered count.
// Latency: first tick PRESC_DIV-1 edges after reset release. Backpressure: none, free-running.
module led_prescaler #(
    parameter int PRESC_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PW'(1);
        end
    end

    // Gated by reset so a divide-by-one build still shows tick=0 while held in reset.
    assign tick = rst && (count_q == LAST);

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM on a shared prescaled time base.
// Latency: led reflects a config write at the second edge after the write edge. Backpressure: none.
module led_bank
    import led_pkg::*;
#(
    parameter  int NUM_LEDS  = 4,
    parameter  int CNT_W     = 8,
    parameter  int PRESC_DIV = 1000,
    localparam int CH_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_val,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    logic [CNT_W-1:0]    phase_q;
    logic [NUM_LEDS-1:0] drive_nxt;
    logic [NUM_LEDS-1:0] drive_q;

    led_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else if (tick) begin
            phase_q <= phase_q + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        mode_e            mode_q;
        logic [CNT_W-1:0] val_q;
        logic [CNT_W-1:0] bcnt_q;
        logic             bstate_q;
        logic             wr_hit;

        // Indices >= NUM_LEDS never match a channel, so such writes fall through untouched.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_q   <= MODE_OFF;
                val_q    <= '0;
                bcnt_q   <= '0;
                bstate_q <= 1'b0;
            end else if (wr_hit) begin
                mode_q   <= mode_e'(cfg_mode);
                val_q    <= cfg_val;
                bcnt_q   <= '0;
                bstate_q <= 1'b0;
            end else if (tick && (mode_q == MODE_BLINK)) begin
                if (bcnt_q == val_q) begin
                    bcnt_q   <= '0;
                    bstate_q <= ~bstate_q;
                end else begin
                    bcnt_q <= bcnt_q + CNT_W'(1);
                end
            end
        end

        assign drive_nxt[i] = (mode_q == MODE_ON)
                            | ((mode_q == MODE_BLINK) & bstate_q)
                            | ((mode_q == MODE_PWM) & (phase_q < val_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drive_q <= '0;
            led     <= '0;
        end else begin
            drive_q <= drive_nxt;
            led     <= drive_q;
        end
    end

endmodule

// File: tb/tb_led_bank.sv
// Directed self-checking bench for led_bank (PRESC_DIV=4, CNT_W=8; 4- and 5-channel builds).
module tb_led_bank;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_val;
    logic [3:0] led;
    logic       tick;

    logic       cfg5_we;
    logic [2:0] cfg5_ch;
    logic [1:0] cfg5_mode;
    logic [7:0] cfg5_val;
    logic [4:0] led5;
    logic       tick5;

    int checks = 0;
    int errors = 0;
    int hi_cnt;

    led_bank #(.NUM_LEDS(4), .CNT_W(8), .PRESC_DIV(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_val  (cfg_val),
        .led      (led),
        .tick     (tick)
    );

    led_bank #(.NUM_LEDS(5), .CNT_W(8), .PRESC_DIV(4)) u_dut5 (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg5_we),
        .cfg_ch   (cfg5_ch),
        .cfg_mode (cfg5_mode),
        .cfg_val  (cfg5_val),
        .led      (led5),
        .tick     (tick5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] val);
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_val  = val;
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic wr5(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] val);
        cfg5_ch   = ch;
        cfg5_mode = mode;
        cfg5_val  = val;
        cfg5_we   = 1'b1;
        step();
        cfg5_we   = 1'b0;
    endtask

    // Advance until tick is seen high, so the next edge is a tick edge.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("wait_tick", 32'(tick), 32'd1);
    endtask

    initial begin
        logic exp_b;
        rst = 1'b0;
        cfg_we = 1'b0;  cfg_ch = '0;  cfg_mode = '0;  cfg_val = '0;
        cfg5_we = 1'b0; cfg5_ch = '0; cfg5_mode = '0; cfg5_val = '0;

        // Reset state and time base
        step();
        step();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_led5", 32'(led5), 32'h0);
        chk("rst_tick5", 32'(tick5), 32'h0);
        rst = 1'b1;
        step(); chk("tick_e1", 32'(tick), 32'd0);
        step(); chk("tick_e2", 32'(tick), 32'd0);
        step(); chk("tick_e3", 32'(tick), 32'd1);
        step(); chk("tick_e4", 32'(tick), 32'd0);
        step(); chk("tick_e5", 32'(tick), 32'd0);
        step(); chk("tick_e6", 32'(tick), 32'd0);
        step(); chk("tick_e7", 32'(tick), 32'd1);

        // ON on ch0: visible at the second edge after the write edge
        wr(2'd0, 2'd1, 8'd0);
        chk("on_e0", 32'(led), 32'h0);
        step(); chk("on_e1", 32'(led), 32'h0);
        step(); chk("on_e2", 32'(led), 32'h1);

        // PWM ch1 duty 64/256
        wr(2'd1, 2'd3, 8'd64);
        step();
        step();
        hi_cnt = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            if (led[1] === 1'b1) hi_cnt++;
        end
        chk("pwm64_high_clks", 32'(hi_cnt), 32'd256);
        chk("pwm_on_kept", 32'(led[0]), 32'd1);

        wr(2'd1, 2'd3, 8'd0);
        step();
        step();
        hi_cnt = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            if (led[1] === 1'b1) hi_cnt++;
        end
        chk("pwm0_high_clks", 32'(hi_cnt), 32'd0);

        // Out-of-range channel on the 5-channel build
        wr5(3'd5, 2'd1, 8'd0);
        step(); step(); step();
        chk("oor_on_ignored", 32'(led5), 32'h00);
        wr5(3'd4, 2'd1, 8'd0);
        step(); step();
        chk("ch4_on", 32'(led5), 32'h10);
        wr5(3'd7, 2'd0, 8'd0);
        wr5(3'd6, 2'd0, 8'd0);
        step(); step(); step();
        chk("oor_off_ignored", 32'(led5), 32'h10);

        // BLINK ch2 val=2, written on a non-tick edge
        wait_tick();
        step();
        wr(2'd2, 2'd2, 8'd2);
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_b = (k < 13) ? 1'b0 : ((((k - 13) / 12) % 2) == 0);
            chk($sformatf("blink_k%0d", k), 32'(led[2]), 32'(exp_b));
        end

        // Rewrite ch2 on a tick edge while lit: returns to 0, count restarts
        wait_tick();
        wr(2'd2, 2'd2, 8'd2);
        for (int m = 1; m <= 16; m++) begin
            step();
            exp_b = (m <= 1) ? 1'b1 : (m >= 14);
            chk($sformatf("rewrite_m%0d", m), 32'(led[2]), 32'(exp_b));
        end

        // Asynchronous reset between edges while led[2]=1
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_led5", 32'(led5), 32'h00);
        step();
        chk("rst_hold_led", 32'(led), 32'h0);
        rst = 1'b1;
        step(); step(); step();
        chk("post_rst_tick", 32'(tick), 32'd1);
        for (int k = 0; k < 27; k++) step();
        chk("post_rst_all_off", 32'(led), 32'h0);
        chk("post_rst_all_off5", 32'(led5), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
